// File: rtl/ex_alu_seq_pkg.sv
// ex_alu_seq_pkg
//   Shared definitions for the EX-stage execute unit: ALU op codes
//   (5-bit, legacy ADD..SRA values retained), the op-class helper that
//   separates iterative mul/div ops from single-cycle ops, and the
//   control FSM state type.
package ex_alu_seq_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND    = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR     = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR    = 5'd4;
    localparam logic [OP_W-1:0] ALU_SLL    = 5'd5;
    localparam logic [OP_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [OP_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [OP_W-1:0] ALU_SLT    = 5'd8;
    localparam logic [OP_W-1:0] ALU_SLTU   = 5'd9;
    localparam logic [OP_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [OP_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [OP_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [OP_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [OP_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [OP_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [OP_W-1:0] ALU_REM    = 5'd16;
    localparam logic [OP_W-1:0] ALU_REMU   = 5'd17;

    // Class check replacing the old ALU_IS_MULDIV macro.
    function automatic logic alu_is_muldiv(input logic [OP_W-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic alu_is_div(input logic [OP_W-1:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } ex_state_e;

endpackage

// File: rtl/ex_alu_seq_muldiv_iter.sv
// muldiv_iter
//   Iterative multiply (shift-add) / divide (restoring) datapath working on
//   operand magnitudes, one step per cycle for XLEN cycles, followed by a
//   sign fix-up of the final accumulator.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     start           load operands and begin (ignored while flush)
//     flush           abandon any iteration in progress
//     op, a, b        op code and operands, sampled on start
//     busy            iterations in progress
//     done            one-cycle pulse; result valid in that cycle
//     result          fixed-up result (valid while done)
module muldiv_iter
    import ex_alu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   md;       // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt;
    logic              running;
    logic              done_q;
    logic              div_q;
    logic              hi_q;
    logic              rem_q;
    logic              neg_q;

    // Operand decode at start
    logic            sa, sb, s_div;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        sa    = ((op == ALU_MULH) || (op == ALU_MULHSU) ||
                 (op == ALU_DIV)  || (op == ALU_REM)) && a[XLEN-1];
        sb    = ((op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM)) && b[XLEN-1];
        s_div = alu_is_div(op);
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // One iteration step
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        add_sum = '0;
        rem_sh  = '0;
        diff    = '0;
        acc_nxt = acc;
        if (div_q) begin
            // Shift {rem,quot} left; keep the trial subtraction if non-negative.
            rem_sh = acc[2*XLEN-1:XLEN-1];
            diff   = rem_sh - {1'b0, md};
            if (!diff[XLEN])
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            // Conditional add into the high half, then shift right including carry.
            add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md} : '0);
            acc_nxt = {add_sum, acc[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            md      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= 1'b0;
            rem_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else if (flush) begin
            running <= 1'b0;
            done_q  <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            done_q  <= 1'b0;
            cnt     <= CNT_W'(XLEN - 1);
            div_q   <= s_div;
            hi_q    <= (op != ALU_MUL);
            rem_q   <= (op == ALU_REM) || (op == ALU_REMU);
            neg_q   <= ((op == ALU_REM) ? sa : (sa ^ sb));
            if (s_div) begin
                acc <= {{XLEN{1'b0}}, mag_a};
                md  <= mag_b;
            end else begin
                acc <= {{XLEN{1'b0}}, mag_b};
                md  <= mag_a;
            end
        end else if (running) begin
            acc <= acc_nxt;
            if (cnt == '0) begin
                running <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    // Sign fix-up of the final accumulator
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        result = '0;
        if (div_q)
            result = rem_q ? rem : quo;
        else
            result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    assign busy = running;
    assign done = done_q;

endmodule

// File: rtl/ex_alu_seq.sv
// ex_alu_seq
//   Handshaked EX-stage execute unit: RV32I ALU ops in one cycle, RV32M
//   mul/div ops via muldiv_iter. Results and tags are registered and held
//   until consumed.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     in_valid/in_ready                op request handshake
//     in_op, in_a, in_b, in_tag        op code, operands, opaque tag
//     flush                            drop accepted / in-flight op
//     out_valid/out_ready              result handshake
//     out_result, out_tag              registered result and its tag
//     busy                             iterative op in progress
module ex_alu_seq
    import ex_alu_seq_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    ex_state_e state_q, state_d;

    logic             accept;
    logic             special;
    logic             go_iter;
    logic             go_single;
    logic [XLEN-1:0]  single_res;
    logic [TAG_W-1:0] tag_q;
    logic             mdu_busy;
    logic             mdu_done;
    logic [XLEN-1:0]  mdu_result;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go_iter)        state_d = ST_BUSY;
                    else if (go_single) state_d = ST_DONE;
                end
                ST_BUSY: begin
                    if (mdu_done) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (go_iter)        state_d = ST_BUSY;
                        else if (go_single) state_d = ST_DONE;
                        else                state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake / control outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready && !flush;
        // Divide-by-zero and signed overflow finish as single-cycle ops.
        special   = alu_is_div(in_op) &&
                    ((in_b == '0) ||
                     (((in_op == ALU_DIV) || (in_op == ALU_REM)) &&
                      (in_a == SMIN) && (in_b == '1)));
        go_iter   = accept && alu_is_muldiv(in_op) && !special;
        go_single = accept && !go_iter;
    end

    // Single-cycle ALU, including the division special cases
    always_comb begin
        single_res = '0;
        case (in_op)
            ALU_ADD:  single_res = in_a + in_b;
            ALU_SUB:  single_res = in_a - in_b;
            ALU_AND:  single_res = in_a & in_b;
            ALU_OR:   single_res = in_a | in_b;
            ALU_XOR:  single_res = in_a ^ in_b;
            ALU_SLL:  single_res = in_a << in_b[SH_W-1:0];
            ALU_SRL:  single_res = in_a >> in_b[SH_W-1:0];
            ALU_SRA:  single_res = $signed(in_a) >>> in_b[SH_W-1:0];
            ALU_SLT:  single_res = XLEN'($signed(in_a) < $signed(in_b));
            ALU_SLTU: single_res = XLEN'(in_a < in_b);
            ALU_DIV, ALU_DIVU: single_res = (in_b == '0) ? '1 : SMIN;
            ALU_REM, ALU_REMU: single_res = (in_b == '0) ? in_a : '0;
            default:  single_res = '0;
        endcase
    end

    // Output data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
            tag_q      <= '0;
        end else if (go_single) begin
            out_result <= single_res;
            out_tag    <= in_tag;
        end else if (go_iter) begin
            tag_q <= in_tag;
        end else if ((state_q == ST_BUSY) && mdu_done && !flush) begin
            out_result <= mdu_result;
            out_tag    <= tag_q;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (go_iter),
        .flush  (flush),
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    assign busy = mdu_busy;

endmodule

// File: tb/tb_ex_alu_seq.sv
module tb_ex_alu_seq;
    import ex_alu_seq_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    ex_alu_seq #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Present an op at a falling edge; it is accepted on the next rising edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic single(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        issue(op, a, b, tag);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk(name, out_result, exp);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    task automatic iter(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        int n;
        issue(op, a, b, tag);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_res(n);
        chk({name, "_lat"}, 32'(n), 32'd33);
        chk(name, out_result, exp);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    initial begin
        int n;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_result",    out_result,     32'd0);
        chk("rst_tag",       32'(out_tag),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops
        single("add",  ALU_ADD,  32'h7FFF_FFFF, 32'h1,          5'd1, 32'h8000_0000);
        single("and",  ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd2, 32'h00F0_00F0);
        single("sra",  ALU_SRA,  32'h8000_0000, 32'h24,         5'd3, 32'hF800_0000);
        single("srl",  ALU_SRL,  32'h8000_0000, 32'h24,         5'd4, 32'h0800_0000);
        single("sll",  ALU_SLL,  32'h0000_0003, 32'h3F,         5'd5, 32'h8000_0000);
        single("sub",  ALU_SUB,  32'h0,         32'h1,          5'd6, 32'hFFFF_FFFF);
        single("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h1,          5'd7, 32'h1);
        single("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1,          5'd8, 32'h0);
        single("undef", 5'd31,   32'h1234_5678, 32'h1,          5'd9, 32'h0);

        // Multiplies
        iter("mulh",   ALU_MULH,   32'hFFFF_FFFF, 32'h2,          5'd10, 32'hFFFF_FFFF);
        iter("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'h2,          5'd11, 32'h0000_0001);
        iter("mul",    ALU_MUL,    32'hFFFF_FFFF, 32'h2,          5'd12, 32'hFFFF_FFFE);
        iter("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'h2,          5'd13, 32'hFFFF_FFFF);
        iter("mulh_min", ALU_MULH, 32'h8000_0000, 32'h8000_0000,  5'd14, 32'h4000_0000);

        // Divides
        iter("div",    ALU_DIV,  32'hFFFF_FFF9, 32'h2,          5'd15, 32'hFFFF_FFFD);
        iter("rem",    ALU_REM,  32'hFFFF_FFF9, 32'h2,          5'd16, 32'hFFFF_FFFF);
        iter("divu",   ALU_DIVU, 32'd100,       32'd7,          5'd17, 32'd14);
        iter("remu",   ALU_REMU, 32'd100,       32'd7,          5'd18, 32'd2);
        iter("rem_nb", ALU_REM,  32'd7,         32'hFFFF_FFFE,  5'd19, 32'd1);
        single("divu_z",  ALU_DIVU, 32'd5,        32'd0,         5'd20, 32'hFFFF_FFFF);
        single("remu_z",  ALU_REMU, 32'd5,        32'd0,         5'd21, 32'd5);
        single("div_ovf", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000);
        single("rem_ovf", ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0);

        // Back-to-back single-cycle ops: second result one cycle after the first
        single("b2b_a", ALU_ADD, 32'd10, 32'd20, 5'd24, 32'd30);
        single("b2b_b", ALU_XOR, 32'hFF,  32'h0F, 5'd25, 32'hF0);

        // Backpressure: hold the result, offer a new op that must wait
        @(negedge clk);
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd3, 32'd4, 5'd9);
        in_valid = 1'b1;
        in_op    = ALU_OR;
        in_a     = 32'h0000_00A0;
        in_b     = 32'h0000_000B;
        in_tag   = 5'd27;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(out_valid), 32'd1);
            chk("bp_result", out_result,     32'd7);
            chk("bp_tag",    32'(out_tag),   32'd9);
            chk("bp_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid",  32'(out_valid), 32'd1);
        chk("bp_next_result", out_result,     32'h0000_00AB);
        chk("bp_next_tag",    32'(out_tag),   32'd27);
        @(negedge clk);

        // Flush at iteration 10 of a DIVU
        issue(ALU_DIVU, 32'd1000, 32'd3, 5'd28);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy",  32'(busy),      32'd0);
        chk("flush_ready", 32'(in_ready),  32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        single("post_flush", ALU_ADD, 32'h10, 32'h01, 5'd29, 32'h11);

        // Flush blocks acceptance even with in_valid high
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = ALU_ADD;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_noacc", 32'(out_valid), 32'd0);

        // Reset in the middle of a MUL
        single("pre_rst", ALU_ADD, 32'h20, 32'h02, 5'd30, 32'h22);
        issue(ALU_MUL, 32'd6, 32'd7, 5'd31);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy",      32'(busy),      32'd0);
        chk("mrst_result",    out_result,     32'd0);
        chk("mrst_tag",       32'(out_tag),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        iter("post_rst_mul", ALU_MUL, 32'd6, 32'd7, 5'd3, 32'd42);
        wait_res(n);
        chk("end_n", 32'(n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_alu_seq.md
# ex_alu_seq

Parametrised, handshaked execute unit for the EX stage. It covers the full RV32I integer ALU op set plus the RV32M multiply/divide group. Single-cycle ops return a registered result one cycle after acceptance. MUL*/DIV*/REM* run on an iterative shift-add / restoring-divide datapath over XLEN cycles. Sits between ID/EX pipeline register and EX/MEM register; stalls the pipe through `in_ready`.

## Interface
- `XLEN`, 32, operand/result width; power of two, 8..64
- `TAG_W`, 5, width of opaque tag (destination reg index) carried alongside the op
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  op request valid
- `in_ready`  out  1  unit can accept an op this cycle
- `in_op`  in  5  operation code, `ALU_*` encoding
- `in_a`  in  XLEN  operand A (rs1)
- `in_b`  in  XLEN  operand B (rs2 / immediate)
- `in_tag`  in  TAG_W  tag, returned unchanged with the result
- `flush`  in  1  kill any accepted/in-flight op
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result this cycle
- `out_result`  out  XLEN  result
- `out_tag`  out  TAG_W  tag of the op producing `out_result`
- `busy`  out  1  iterative op in progress

## Operation
- Ops, single-cycle:
  - ADD, SUB: modulo 2^XLEN.
  - AND, OR, XOR: bitwise; never logical `&&`/`||`.
  - SLL, SRL, SRA: shift amount = `in_b[log2(XLEN)-1:0]`.
  - SLT, SLTU: result 1 or 0, zero-extended.
- Ops, iterative:
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU, MULHU return the high XLEN bits: signed×signed, signed×unsigned, unsigned×unsigned respectively.
  - DIV/DIVU/REM/REMU.
- Undefined op code: single-cycle, result 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE + accept of a single-cycle op → DONE; result registered.
  - IDLE + accept of a mul/div op → BUSY; iteration counter loaded with XLEN−1.
  - BUSY: one iteration per cycle. At count 0, apply sign fix-up → DONE.
  - DONE + `out_ready` → IDLE, or directly to the next op's state if a new op is accepted the same cycle.
  - DONE + !`out_ready`: hold `out_result`/`out_tag` stable.
- Accept = `in_valid && in_ready`.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`).
- Signed mul/div operate on magnitudes. Negate the result if the operand signs differ. The remainder takes the dividend's sign.
- Division special cases bypass BUSY and complete as single-cycle ops:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = −2^(XLEN−1); remainder = 0.
- `flush` (synchronous, highest priority):
  - Next state IDLE; `out_valid` low next cycle.
  - No accept in a flush cycle, even if `in_valid`=1.

## Timing
- Reset values:
  - state IDLE; `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_result`=0, `out_tag`=0, counter=0.
- Single-cycle op: accepted at edge k → `out_valid`=1 after edge k.
- Iterative op: accepted at edge k → `busy`=1 after edges k..k+XLEN−1 → `out_valid`=1 after edge k+XLEN+1. Latency XLEN+1.
- Back-to-back single-cycle ops with `out_ready`=1 give one result per cycle.
- `out_valid` and all output data are registered; no combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready` only.
- Reset asserted mid-BUSY: immediate return to reset values; partial result discarded.
- `flush` in DONE with `out_ready`=1: result is not considered consumed; dropped.

## Structure
- `define.v` holds all `ALU_*` op codes, widened to 5 bits:
  - The existing ADD, SUB, AND, OR, XOR, SLL, SRL, SRA keep their values.
  - New codes: SLT, SLTU, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Also define an `ALU_IS_MULDIV` class macro.
- Sub-module `muldiv_iter` owns the iterative datapath:
  - 2·XLEN accumulator, counter, sign flags.
  - Controlled by `start`, `op`, and `flush`; returns `done` and `result`.
- The top level owns the FSM, single-cycle ALU, special-case detection, and output registers.

## Test plan
- Reset, then ADD a=0x7FFFFFFF b=1 with `out_ready`=1 → `out_valid` one cycle later, `out_result`=0x80000000. Repeat with AND 0xF0F0F0F0/0x0FF00FF0 → 0x00F000F0.
- Shifts: SRA a=0x80000000 b=0x24 (amount 4) → 0xF8000000. SRL with the same operands → 0x08000000.
- Multiplies, each with 33-cycle latency:
  - MULH a=0xFFFFFFFF (−1) b=2 → 0xFFFFFFFF.
  - MULHU with the same operands → 0x00000001.
  - MUL → 0xFFFFFFFE.
- Divides:
  - DIV a=−7 b=2 → −3 after 33 cycles; REM → −1.
  - DIVU a=5 b=0 → 0xFFFFFFFF after 1 cycle.
  - DIV 0x80000000/−1 → 0x80000000.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result → `out_result`/`out_tag` stable and `in_ready`=0. Release → result consumed; next op accepted in the same cycle.
- Flush and reset:
  - Assert `flush` at iteration 10 of a DIVU → IDLE next cycle; no `out_valid`; the following ADD completes normally.
  - Assert `rst_n`=0 mid-MUL → all outputs at reset values immediately.
